bridge_master_arbiter: RTL and testbench

Round-robin arbiter that shares one bridge_master between N_REQ flit buffers, each a NoC-side requester. It accepts one merged request at a time, forwards it to the bridge and routes the merged response back to the requester that issued it. Only one transaction is in flight at any time, which matches the bridge's single-outstanding behaviour.

---
 rtl/bridge_master_arbiter_pkg.sv | 21 ++
 rtl/bridge_master_arbiter_if.sv | 46 ++++
 rtl/bridge_master_arbiter_rr_pick.sv | 40 ++++
 rtl/bridge_master_arbiter.sv | 133 +++++++++++++
 tb/tb_bridge_master_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bridge_master_arbiter_pkg.sv
// bridge_arb_pkg: shared types for the bridge master arbiter.
//   arb_state_e : transaction FSM states
//   id_w()      : width of a requester index for n requesters (min 1)
`ifndef MERGED_REQUEST_WIDTH
`define MERGED_REQUEST_WIDTH 72
`endif

package bridge_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    WAIT_RESP = 2'd2,
    RETURN    = 2'd3
  } arb_state_e;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bridge_master_arbiter_if.sv
// bridge_master_arbiter_if: requester-side and bridge-side handshake bundle.
//   master modport : the arbiter (consumes requests, produces responses,
//                    produces bridge requests, consumes bridge responses)
//   slave modport  : the environment (flit buffers + bridge_master)
// Requester i uses bit i of the vectors and slice [i*W +: W] of req_data.
`ifndef MERGED_REQUEST_WIDTH
`define MERGED_REQUEST_WIDTH 72
`endif

interface bridge_master_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = `MERGED_REQUEST_WIDTH
);
  // requester side
  logic [N_REQ-1:0]   req_avail;
  logic [N_REQ-1:0]   req_taken;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   rsp_avail;
  logic [N_REQ-1:0]   rsp_taken;
  logic [W-1:0]       rsp_data;
  // bridge side
  logic               data_to_bridge_avail;
  logic               data_to_bridge_taken;
  logic [W-1:0]       merged_request_buffer_to_bridge;
  logic               data_from_bridge_avail;
  logic               data_from_bridge_taken;
  logic [W-1:0]       merged_request_bridge_to_buffer;

  modport master (
    input  req_avail, req_data, rsp_taken,
    input  data_to_bridge_taken, data_from_bridge_avail,
    input  merged_request_bridge_to_buffer,
    output req_taken, rsp_avail, rsp_data,
    output data_to_bridge_avail, merged_request_buffer_to_bridge,
    output data_from_bridge_taken
  );

  modport slave (
    output req_avail, req_data, rsp_taken,
    output data_to_bridge_taken, data_from_bridge_avail,
    output merged_request_bridge_to_buffer,
    input  req_taken, rsp_avail, rsp_data,
    input  data_to_bridge_avail, merged_request_buffer_to_bridge,
    input  data_from_bridge_taken
  );
endinterface

// File: rtl/bridge_master_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req_i : request vector
//   ptr_i : highest-priority index (must be < N)
//   gnt_o : one-hot grant, first set bit scanning upward from ptr_i, wrapping
//   idx_o : index of the granted bit
//   any_o : at least one request present
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  // One spare bit so ptr + offset (max 2N-2) cannot overflow before the wrap.
  logic [IDW:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = '0;
    // Walk from the farthest offset down to offset 0 so the nearest
    // requester to ptr_i is written last and wins.
    for (int k = N - 1; k >= 0; k--) begin
      j = {1'b0, ptr_i} + (IDW+1)'(k);
      if (j >= (IDW+1)'(N)) j = j - (IDW+1)'(N);
      if (req_i[j[IDW-1:0]]) begin
        gnt_o              = '0;
        gnt_o[j[IDW-1:0]]  = 1'b1;
        idx_o              = j[IDW-1:0];
        any_o              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bridge_master_arbiter.sv
// bridge_master_arbiter: shares one bridge_master between N_REQ requesters,
// one transaction in flight at a time, round-robin among waiting requesters.
//   clk, res  : clock, synchronous active-high reset
//   bus       : requester + bridge handshakes (master modport)
//   busy      : a transaction is in flight
//   grant_id  : owner of the current transaction
// All outputs come straight from flops.
`ifndef MERGED_REQUEST_WIDTH
`define MERGED_REQUEST_WIDTH 72
`endif

module bridge_master_arbiter
  import bridge_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = `MERGED_REQUEST_WIDTH
) (
  input  logic                     clk,
  input  logic                     res,
  bridge_master_arbiter_if.master  bus,
  output logic                     busy,
  output logic [id_w(N_REQ)-1:0]   grant_id
);

  localparam int IDW = id_w(N_REQ);

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [W-1:0]     req_reg_q, req_reg_d;
  logic [W-1:0]     rsp_reg_q, rsp_reg_d;
  logic [N_REQ-1:0] req_taken_q, req_taken_d;
  logic [N_REQ-1:0] rsp_avail_q, rsp_avail_d;
  logic             dtb_avail_q, dtb_avail_d;
  logic             dfb_taken_q, dfb_taken_d;
  logic             busy_q, busy_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic [W-1:0]     sel_req;

  rr_pick #(.N(N_REQ), .IDW(IDW)) u_pick (
    .req_i (bus.req_avail),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // One-hot AND-OR mux of the winner's payload.
  always_comb begin
    sel_req = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pick_gnt[i]) sel_req = sel_req | bus.req_data[i*W +: W];
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    req_reg_d   = req_reg_q;
    rsp_reg_d   = rsp_reg_q;
    req_taken_d = '0;
    rsp_avail_d = rsp_avail_q;
    dtb_avail_d = dtb_avail_q;
    dfb_taken_d = 1'b0;
    unique case (state_q)
      IDLE: if (pick_any) begin
        req_reg_d   = sel_req;
        owner_d     = pick_idx;
        req_taken_d = pick_gnt;
        dtb_avail_d = 1'b1;    // presented to the bridge alongside req_taken
        state_d     = GRANT;
      end
      GRANT: if (bus.data_to_bridge_taken) begin
        dtb_avail_d = 1'b0;
        state_d     = WAIT_RESP;
      end
      WAIT_RESP: if (bus.data_from_bridge_avail) begin
        rsp_reg_d            = bus.merged_request_bridge_to_buffer;
        dfb_taken_d          = 1'b1;
        rsp_avail_d          = '0;
        rsp_avail_d[owner_q] = 1'b1;
        state_d              = RETURN;
      end
      RETURN: if (bus.rsp_taken[owner_q]) begin
        rsp_avail_d = '0;
        // Finished requester drops to lowest priority.
        rr_ptr_d    = (owner_q == IDW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      req_reg_q   <= '0;
      rsp_reg_q   <= '0;
      req_taken_q <= '0;
      rsp_avail_q <= '0;
      dtb_avail_q <= 1'b0;
      dfb_taken_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      req_reg_q   <= req_reg_d;
      rsp_reg_q   <= rsp_reg_d;
      req_taken_q <= req_taken_d;
      rsp_avail_q <= rsp_avail_d;
      dtb_avail_q <= dtb_avail_d;
      dfb_taken_q <= dfb_taken_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_taken                       = req_taken_q;
  assign bus.rsp_avail                       = rsp_avail_q;
  assign bus.rsp_data                        = rsp_reg_q;
  assign bus.data_to_bridge_avail            = dtb_avail_q;
  assign bus.merged_request_buffer_to_bridge = req_reg_q;
  assign bus.data_from_bridge_taken          = dfb_taken_q;
  assign busy                                = busy_q;
  assign grant_id                            = owner_q;

endmodule

// File: tb/tb_bridge_master_arbiter.sv
// Bench for bridge_master_arbiter: cycle-stepped requester/bridge models,
// round-robin reference computed by scanning pending requesters from the
// pointer, randomized payloads, delays and arrivals.
`ifndef MERGED_REQUEST_WIDTH
`define MERGED_REQUEST_WIDTH 72
`endif

module tb_bridge_master_arbiter;
  import bridge_arb_pkg::*;

  localparam int N   = 4;
  localparam int W   = `MERGED_REQUEST_WIDTH;
  localparam int IDW = id_w(N);

  logic           clk = 1'b0;
  logic           res = 1'b1;
  logic           busy;
  logic [IDW-1:0] grant_id;

  bridge_master_arbiter_if #(.N_REQ(N), .W(W)) bus_if ();

  bridge_master_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk      (clk),
    .res      (res),
    .bus      (bus_if.master),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  int           nvec = 0;
  int           nerr = 0;
  int           mptr;            // model round-robin pointer
  logic [N-1:0] pend;            // model pending requesters
  logic [W-1:0] pl [N];          // payload each requester is presenting

  typedef struct {
    int           win;
    int           lat;
    int           gid;
    bit           onehot;
    bit           dtb_up;
    bit           dtb_drop;
    logic [W-1:0] req_seen;
    logic [N-1:0] rsp_vec;
    logic [W-1:0] rsp_seen;
    int           pulses;
    bit           held_ok;
    bit           end_ok;
    bit           timeout;
  } obs_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Spec rule: first pending requester scanning upward from ptr, wrapping.
  function automatic int model_pick(input logic [N-1:0] p, input int ptr);
    for (int i = 0; i < N; i++)
      if (p[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot_of(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] d);
    pl[i] = d;
    bus_if.req_data[i*W +: W] = d;
    bus_if.req_avail[i] = 1'b1;
    pend[i] = 1'b1;
  endtask

  task automatic reset_dut();
    res = 1'b1;
    bus_if.req_avail = '0;
    bus_if.req_data = '0;
    bus_if.rsp_taken = '0;
    bus_if.data_to_bridge_taken = 1'b0;
    bus_if.data_from_bridge_avail = 1'b0;
    bus_if.merged_request_bridge_to_buffer = '0;
    pend = '0;
    mptr = 0;
    step();
    step();
    res = 1'b0;
  endtask

  // One full transaction driven by requester + bridge models; returns what
  // was observed. Called in the cycle where the requests are presented.
  task automatic do_txn(input logic [W-1:0] rsp_word, input int rsp_delay,
                        input bit stale, input int hold, input int wrong,
                        input logic [N-1:0] late, output obs_t o);
    int n;
    logic [N-1:0] m;
    o.win = -1; o.lat = 0; o.gid = -1; o.onehot = 0; o.dtb_up = 0;
    o.dtb_drop = 0; o.req_seen = '0; o.rsp_vec = '0; o.rsp_seen = '0;
    o.pulses = 0; o.held_ok = 1; o.end_ok = 0; o.timeout = 0;
    n = 0;
    do begin step(); n++; end while (bus_if.req_taken == '0 && n < 10);
    if (bus_if.req_taken == '0) begin o.timeout = 1; return; end
    o.lat = n;
    o.onehot = $onehot(bus_if.req_taken);
    for (int i = N - 1; i >= 0; i--) if (bus_if.req_taken[i]) o.win = i;
    o.gid = int'(grant_id);
    o.dtb_up = bus_if.data_to_bridge_avail;
    o.req_seen = bus_if.merged_request_buffer_to_bridge;
    step();                                   // requester drops, bridge takes
    bus_if.req_avail[o.win] = 1'b0;
    bus_if.data_to_bridge_taken = 1'b1;
    step();
    bus_if.data_to_bridge_taken = 1'b0;
    bus_if.req_avail = bus_if.req_avail | late;
    o.dtb_drop = (bus_if.data_to_bridge_avail === 1'b0) && (busy === 1'b1);
    repeat (rsp_delay) step();
    bus_if.data_from_bridge_avail = 1'b1;
    bus_if.merged_request_bridge_to_buffer = rsp_word;
    n = 0;
    do begin
      step(); n++;
      if (bus_if.data_from_bridge_taken) o.pulses++;
    end while (!bus_if.data_from_bridge_taken && n < 20);
    if (!bus_if.data_from_bridge_taken) begin
      o.timeout = 1;
      bus_if.data_from_bridge_avail = 1'b0;
      return;
    end
    o.rsp_vec = bus_if.rsp_avail;
    o.rsp_seen = bus_if.rsp_data;
    step();
    for (int j = 0; j <= hold; j++) begin
      if (j > 0) step();
      if (bus_if.data_from_bridge_taken) o.pulses++;
      if (bus_if.rsp_avail !== o.rsp_vec || bus_if.rsp_data !== o.rsp_seen ||
          busy !== 1'b1 || bus_if.req_taken !== '0) o.held_ok = 0;
      if (j == 0 && !stale) bus_if.data_from_bridge_avail = 1'b0;
      if (j == 1) bus_if.data_from_bridge_avail = 1'b0;
      m = '0;
      if (wrong >= 0 && j == 1) m[wrong] = 1'b1;
      if (j == hold) m[o.win] = 1'b1;
      bus_if.rsp_taken = m;
    end
    step();
    bus_if.rsp_taken = '0;
    bus_if.data_from_bridge_avail = 1'b0;
    if (bus_if.data_from_bridge_taken) o.pulses++;
    o.end_ok = (bus_if.rsp_avail === '0) && (busy === 1'b0);
  endtask

  task automatic test_reset();
    res = 1'b1;
    bus_if.req_avail = '1;
    bus_if.req_data = '1;
    bus_if.rsp_taken = '1;
    bus_if.data_to_bridge_taken = 1'b1;
    bus_if.data_from_bridge_avail = 1'b1;
    bus_if.merged_request_bridge_to_buffer = '1;
    step(); step(); step();
    nvec++; if (bus_if.req_taken !== '0) begin nerr++; $display("FAIL reset_req_taken: got %b want 0", bus_if.req_taken); end
    nvec++; if (bus_if.rsp_avail !== '0) begin nerr++; $display("FAIL reset_rsp_avail: got %b want 0", bus_if.rsp_avail); end
    nvec++; if (bus_if.rsp_data !== '0) begin nerr++; $display("FAIL reset_rsp_data: got %h want 0", bus_if.rsp_data); end
    nvec++; if (bus_if.data_to_bridge_avail !== 1'b0) begin nerr++; $display("FAIL reset_dtb_avail: got %b want 0", bus_if.data_to_bridge_avail); end
    nvec++; if (bus_if.merged_request_buffer_to_bridge !== '0) begin nerr++; $display("FAIL reset_dtb_data: got %h want 0", bus_if.merged_request_buffer_to_bridge); end
    nvec++; if (bus_if.data_from_bridge_taken !== 1'b0) begin nerr++; $display("FAIL reset_dfb_taken: got %b want 0", bus_if.data_from_bridge_taken); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
    nvec++; if (grant_id !== '0) begin nerr++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    reset_dut();
  endtask

  task automatic test_single();
    obs_t o;
    logic [W-1:0] d, r;
    reset_dut();
    d = rnd_w();
    d[35:0] = {32'hDEADBEEF, 4'h1};
    r = {d[W-1:4], 4'h0};                     // bresp=0 merge from the bridge
    set_req(0, d);
    do_txn(r, 2, 0, 0, -1, '0, o);
    nvec++; if (o.timeout) begin nerr++; $display("FAIL single_timeout: got timeout want completion"); end
    nvec++; if (o.lat !== 1) begin nerr++; $display("FAIL single_latency: got %0d want 1", o.lat); end
    nvec++; if (o.win !== 0 || !o.onehot) begin nerr++; $display("FAIL single_win: got %0d onehot %0d want 0 onehot 1", o.win, o.onehot); end
    nvec++; if (!o.dtb_up) begin nerr++; $display("FAIL single_dtb_avail: got 0 want 1 in grant cycle"); end
    nvec++; if (o.req_seen !== d) begin nerr++; $display("FAIL single_req_data: got %h want %h", o.req_seen, d); end
    nvec++; if (!o.dtb_drop) begin nerr++; $display("FAIL single_dtb_drop: got still high want 0"); end
    nvec++; if (o.rsp_vec !== 4'b0001) begin nerr++; $display("FAIL single_rsp_avail: got %b want 0001", o.rsp_vec); end
    nvec++; if (o.rsp_seen !== r) begin nerr++; $display("FAIL single_rsp_data: got %h want %h", o.rsp_seen, r); end
    nvec++; if (o.pulses !== 1) begin nerr++; $display("FAIL single_dfb_pulses: got %0d want 1", o.pulses); end
    nvec++; if (!o.end_ok) begin nerr++; $display("FAIL single_end: got busy/rsp_avail still high want idle"); end
    pend[0] = 1'b0;
    mptr = 1;
  endtask

  task automatic test_simultaneous();
    obs_t o;
    logic [W-1:0] r;
    int e;
    reset_dut();
    for (int i = 0; i < N; i++) set_req(i, rnd_w());
    for (int k = 0; k < 5; k++) begin
      e = model_pick(pend, mptr);
      r = rnd_w();
      do_txn(r, k % 3, 0, 0, -1, '0, o);
      nvec++; if (o.timeout) begin nerr++; $display("FAIL simul_timeout[%0d]: got timeout want completion", k); end
      nvec++; if (o.win !== e) begin nerr++; $display("FAIL simul_win[%0d]: got %0d want %0d", k, o.win, e); end
      nvec++; if (o.gid !== e) begin nerr++; $display("FAIL simul_grant_id[%0d]: got %0d want %0d", k, o.gid, e); end
      nvec++; if (o.req_seen !== pl[e]) begin nerr++; $display("FAIL simul_req_data[%0d]: got %h want %h", k, o.req_seen, pl[e]); end
      nvec++; if (o.rsp_vec !== onehot_of(e)) begin nerr++; $display("FAIL simul_rsp_avail[%0d]: got %b want %b", k, o.rsp_vec, onehot_of(e)); end
      nvec++; if (o.rsp_seen !== r) begin nerr++; $display("FAIL simul_rsp_data[%0d]: got %h want %h", k, o.rsp_seen, r); end
      pend[e] = 1'b0;
      mptr = (e + 1) % N;
      if (k < 4) set_req(e, rnd_w());
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    logic [W-1:0] r;
    int e;
    reset_dut();
    set_req(2, rnd_w());
    set_req(3, rnd_w());
    e = model_pick(pend, mptr);
    r = rnd_w();
    do_txn(r, 1, 0, 20, -1, '0, o);
    nvec++; if (o.win !== e) begin nerr++; $display("FAIL bp_win: got %0d want %0d", o.win, e); end
    nvec++; if (o.rsp_vec !== onehot_of(e)) begin nerr++; $display("FAIL bp_rsp_avail: got %b want %b", o.rsp_vec, onehot_of(e)); end
    nvec++; if (!o.held_ok) begin nerr++; $display("FAIL bp_hold: got response/busy changed or new grant want stable for 20 cycles"); end
    nvec++; if (!o.end_ok) begin nerr++; $display("FAIL bp_complete: got still busy want idle one cycle after rsp_taken"); end
    pend[e] = 1'b0;
    mptr = (e + 1) % N;
    e = model_pick(pend, mptr);
    r = rnd_w();
    do_txn(r, 0, 0, 0, -1, '0, o);
    nvec++; if (o.win !== e || o.rsp_seen !== r) begin nerr++; $display("FAIL bp_next: got port %0d data %h want port %0d data %h", o.win, o.rsp_seen, e, r); end
    pend[e] = 1'b0;
    mptr = (e + 1) % N;
  endtask

  task automatic test_stale_avail();
    obs_t o;
    logic [W-1:0] r;
    int e;
    for (int k = 0; k < 2; k++) begin
      set_req(2, rnd_w());
      e = model_pick(pend, mptr);
      r = rnd_w();
      do_txn(r, k, 1, 0, -1, '0, o);
      nvec++; if (o.pulses !== 1) begin nerr++; $display("FAIL stale_dfb_pulses[%0d]: got %0d want 1", k, o.pulses); end
      nvec++; if (o.win !== e || o.rsp_seen !== r) begin nerr++; $display("FAIL stale_rsp[%0d]: got port %0d data %h want port %0d data %h", k, o.win, o.rsp_seen, e, r); end
      nvec++; if (!o.end_ok) begin nerr++; $display("FAIL stale_end[%0d]: got still busy want idle", k); end
      pend[e] = 1'b0;
      mptr = (e + 1) % N;
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    logic [W-1:0] r;
    int e, n;
    set_req(1, rnd_w());
    n = 0;
    do begin step(); n++; end while (bus_if.req_taken == '0 && n < 10);
    nvec++; if (bus_if.req_taken == '0) begin nerr++; $display("FAIL rstmid_grant: got no req_taken want grant"); end
    step();
    bus_if.req_avail[1] = 1'b0;
    bus_if.data_to_bridge_taken = 1'b1;
    step();
    bus_if.data_to_bridge_taken = 1'b0;
    step();
    res = 1'b1;
    step();
    res = 1'b0;
    pend = '0;
    mptr = 0;
    nvec++; if (busy !== 1'b0 || grant_id !== '0) begin nerr++; $display("FAIL rstmid_state: got busy %b grant_id %0d want 0 0", busy, grant_id); end
    nvec++; if ({bus_if.req_taken, bus_if.rsp_avail, bus_if.data_to_bridge_avail, bus_if.data_from_bridge_taken} !== '0)
      begin nerr++; $display("FAIL rstmid_ctrl: got %b want 0", {bus_if.req_taken, bus_if.rsp_avail, bus_if.data_to_bridge_avail, bus_if.data_from_bridge_taken}); end
    nvec++; if (bus_if.rsp_data !== '0 || bus_if.merged_request_buffer_to_bridge !== '0) begin nerr++; $display("FAIL rstmid_data: got %h %h want 0 0", bus_if.rsp_data, bus_if.merged_request_buffer_to_bridge); end
    set_req(1, rnd_w());
    set_req(3, rnd_w());
    for (int k = 0; k < 2; k++) begin
      e = model_pick(pend, mptr);
      r = rnd_w();
      do_txn(r, 1, 0, 1, -1, '0, o);
      nvec++; if (o.win !== e) begin nerr++; $display("FAIL rstmid_win[%0d]: got %0d want %0d", k, o.win, e); end
      nvec++; if (o.req_seen !== pl[e] || o.rsp_seen !== r || !o.end_ok) begin nerr++; $display("FAIL rstmid_txn[%0d]: got req %h rsp %h end %0d want %h %h 1", k, o.req_seen, o.rsp_seen, o.end_ok, pl[e], r); end
      pend[e] = 1'b0;
      mptr = (e + 1) % N;
    end
  endtask

  task automatic test_wrong_port();
    obs_t o;
    logic [W-1:0] r;
    set_req(0, rnd_w());
    r = rnd_w();
    do_txn(r, 1, 0, 5, 1, '0, o);
    nvec++; if (o.win !== 0) begin nerr++; $display("FAIL wrong_win: got %0d want 0", o.win); end
    nvec++; if (!o.held_ok) begin nerr++; $display("FAIL wrong_hold: got rsp_avail[0] dropped on rsp_taken[1] want held"); end
    nvec++; if (o.rsp_vec !== 4'b0001 || !o.end_ok) begin nerr++; $display("FAIL wrong_end: got rsp %b end %0d want 0001 1", o.rsp_vec, o.end_ok); end
    pend[0] = 1'b0;
    mptr = 1;
  endtask

  task automatic test_random();
    obs_t o;
    logic [W-1:0] r;
    logic [N-1:0] late;
    int e;
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) set_req(i, rnd_w());
      if (pend == '0) set_req(int'($urandom_range(0, N - 1)), rnd_w());
      late = ~pend & N'($urandom);
      for (int i = 0; i < N; i++)
        if (late[i]) begin
          pl[i] = rnd_w();
          bus_if.req_data[i*W +: W] = pl[i];
        end
      e = model_pick(pend, mptr);
      r = rnd_w();
      do_txn(r, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), -1, late, o);
      nvec++; if (o.timeout || o.win !== e) begin nerr++; $display("FAIL rand_win[%0d]: got %0d (timeout %0d) want %0d", k, o.win, o.timeout, e); end
      nvec++; if (o.req_seen !== pl[e]) begin nerr++; $display("FAIL rand_req_data[%0d]: got %h want %h", k, o.req_seen, pl[e]); end
      nvec++; if (o.rsp_vec !== onehot_of(e) || o.rsp_seen !== r) begin nerr++; $display("FAIL rand_rsp[%0d]: got %b %h want %b %h", k, o.rsp_vec, o.rsp_seen, onehot_of(e), r); end
      nvec++; if (o.pulses !== 1 || !o.held_ok || !o.end_ok) begin nerr++; $display("FAIL rand_hs[%0d]: got pulses %0d held %0d end %0d want 1 1 1", k, o.pulses, o.held_ok, o.end_ok); end
      pend = pend | late;
      pend[e] = 1'b0;
      mptr = (e + 1) % N;
    end
  endtask

  initial begin
    pend = '0;
    mptr = 0;
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_stale_avail();
    test_reset_mid();
    test_wrong_port();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
